// File: rtl/sn74169_seq_ctrl.sv
// sn74169_seq_ctrl: sequencing front end for an sn74169 4-bit up/down counter.
// Drives the counter's load/enable/direction pins and watches Q/RCOB so the bare
// counter runs as free-run, modulo auto-reload, one-shot or ping-pong sequencer.
// Also counts wraps and flags a disagreement between RCOB and the predicted count.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, stop     run request (sampled when idle/done), abort (always wins)
//   dir, mode       1=up/0=down; 00 free, 01 reload, 10 one-shot, 11 ping-pong
//   preset          load value, latched with dir/mode at start
//   q, rcob         counter readback (rcob active low)
//   a, loadb        counter load data / active-low load
//   enpb, entb      counter active-low count enables
//   u_db            counter direction, 1 = up
//   busy            high in LOAD or RUN
//   wrap_pulse      one-cycle pulse in the cycle q sits at the terminal value
//   wrap_cnt        saturating count of wrap_pulse, cleared by start
//   sync_err        sticky RCOB mismatch flag (modes 00/01 only)
module sn74169_seq_ctrl #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     preset,
  input  logic [W-1:0]     q,
  input  logic             rcob,
  output logic [W-1:0]     a,
  output logic             loadb,
  output logic             enpb,
  output logic             entb,
  output logic             u_db,
  output logic             busy,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic             sync_err
);

  localparam logic [1:0]       MODE_FREE   = 2'b00;
  localparam logic [1:0]       MODE_RELOAD = 2'b01;
  localparam logic [1:0]       MODE_ONCE   = 2'b10;
  localparam logic [1:0]       MODE_PING   = 2'b11;
  localparam logic [CNT_W-1:0] WRAP_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state;
  logic         dir_l;
  logic [1:0]   mode_l;
  logic [W-1:0] preset_l;

  logic [W-1:0] term;
  logic [W-1:0] nq;
  logic         tc_next;
  logic         active;

  // Predict the value the counter will hold after the coming edge. While the
  // counter is being loaded (LOAD, or a reload in RUN) that value is preset, so
  // preset==TERM is recognised immediately and reload/one-shot act at once.
  always_comb begin
    term    = dir_l ? '1 : '0;
    active  = (state == LOAD) || (state == RUN);
    nq      = dir_l ? (q + W'(1)) : (q - W'(1));
    if ((state == LOAD) || !loadb) begin
      nq = preset_l;
    end
    tc_next = active && (nq == term);
  end

  // Controller state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dir_l      <= 1'b1;
      mode_l     <= MODE_FREE;
      preset_l   <= '0;
      a          <= '0;
      loadb      <= 1'b1;
      enpb       <= 1'b1;
      entb       <= 1'b1;
      u_db       <= 1'b1;
      busy       <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      sync_err   <= 1'b0;
    end else begin
      // Count the pulse shown this cycle; a start below overrides with a clear.
      if (wrap_pulse && (wrap_cnt != WRAP_MAX)) begin
        wrap_cnt <= wrap_cnt + CNT_W'(1);
      end
      wrap_pulse <= 1'b0;

      if (stop) begin
        state <= IDLE;
        loadb <= 1'b1;
        enpb  <= 1'b1;
        entb  <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state    <= LOAD;
              dir_l    <= dir;
              mode_l   <= mode;
              preset_l <= preset;
              a        <= preset;
              u_db     <= dir;
              loadb    <= 1'b0;
              enpb     <= 1'b1;
              entb     <= 1'b1;
              busy     <= 1'b1;
              wrap_cnt <= '0;
              sync_err <= 1'b0;
            end
          end

          LOAD, RUN: begin
            // RCOB is only meaningful when the direction never changes mid-run.
            if ((state == RUN) && ((mode_l == MODE_FREE) || (mode_l == MODE_RELOAD)) &&
                (rcob != !(q == term))) begin
              sync_err <= 1'b1;
            end
            state <= RUN;
            loadb <= 1'b1;
            enpb  <= 1'b0;
            entb  <= 1'b0;
            if (tc_next) begin
              wrap_pulse <= 1'b1;
              case (mode_l)
                MODE_RELOAD: begin
                  loadb <= 1'b0;
                  a     <= preset_l;
                end
                MODE_ONCE: begin
                  state <= DONE;
                  enpb  <= 1'b1;
                  entb  <= 1'b1;
                  busy  <= 1'b0;
                end
                MODE_PING: begin
                  u_db  <= ~u_db;
                  dir_l <= ~dir_l;
                end
                default: ;
              endcase
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sn74169_seq_ctrl.sv
// Bench for sn74169_seq_ctrl: a behavioural sn74169 closes the loop, and a
// closed-form model of the expected sequence (position in the run -> outputs)
// predicts every cycle. Directed scenarios first, then randomized runs.
module tb_sn74169_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, dir;
  logic [1:0] mode;
  logic [3:0] preset, q, a;
  logic       rcob, loadb, enpb, entb, u_db, busy, wrap_pulse, sync_err;
  logic [7:0] wrap_cnt;

  int total = 0;
  int bad   = 0;
  int wexp  = 0;
  bit sexp  = 1'b0;

  always #5 clk = ~clk;

  sn74169_seq_ctrl #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .mode(mode),
    .preset(preset), .q(q), .rcob(rcob), .a(a), .loadb(loadb), .enpb(enpb),
    .entb(entb), .u_db(u_db), .busy(busy), .wrap_pulse(wrap_pulse),
    .wrap_cnt(wrap_cnt), .sync_err(sync_err)
  );

  // Behavioural sn74169: load beats count, RCOB low at terminal with ENT low.
  logic [3:0] cq   = 4'd0;
  logic       flip = 1'b0;
  always @(posedge clk) begin
    if (!loadb) cq <= a;
    else if (!enpb && !entb) cq <= u_db ? cq + 4'd1 : cq - 4'd1;
  end
  assign q    = cq;
  assign rcob = !(!entb && (cq == (u_db ? 4'hF : 4'h0))) ^ flip;

  typedef struct {
    int q;
    bit busy;
    bit pulse;
    bit loadb;
    bit enb;
    bit udb;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected outputs t cycles into RUN (t=0: counter holds preset).
  function automatic exp_t ref_at(input int m, input bit up, input int p, input int t);
    exp_t e;
    int term = up ? 15 : 0;
    int d    = up ? 15 - p : p;
    int k, u;
    e.busy = 1'b1; e.enb = 1'b0; e.loadb = 1'b1; e.udb = up; e.pulse = 1'b0;
    case (m)
      0: begin
        e.q     = up ? (p + t) & 15 : (p - t) & 15;
        e.pulse = (e.q == term);
      end
      1: begin
        k       = t % (d + 1);
        e.q     = up ? p + k : p - k;
        e.pulse = (e.q == term);
        e.loadb = !e.pulse;
      end
      2: begin
        if (t < d) e.q = up ? p + t : p - t;
        else begin
          e.q = term; e.busy = 1'b0; e.enb = 1'b1; e.pulse = (t == d);
        end
      end
      default: begin
        // Unfold the triangle onto a 30-step circle: 0..15 rising, 16..29 falling.
        u       = ((up ? p : 30 - p) + t) % 30;
        e.q     = (u <= 15) ? u : 30 - u;
        e.pulse = (t == 0) ? (p == term) : (e.q == 0 || e.q == 15);
        e.udb   = (u < 15);
      end
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".a"}, a, 0);          chk({tag, ".loadb"}, loadb, 1);
    chk({tag, ".enpb"}, enpb, 1);    chk({tag, ".entb"}, entb, 1);
    chk({tag, ".u_db"}, u_db, 1);    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".wrap_pulse"}, wrap_pulse, 0);
    chk({tag, ".wrap_cnt"}, wrap_cnt, 0);
    chk({tag, ".sync_err"}, sync_err, 0);
  endtask

  task automatic check_run(input int m, input bit up, input int p, input int t, output exp_t e);
    e = ref_at(m, up, p, t);
    chk("run.q", q, e.q);              chk("run.busy", busy, e.busy);
    chk("run.wrap_pulse", wrap_pulse, e.pulse);
    chk("run.loadb", loadb, e.loadb);  chk("run.enpb", enpb, e.enb);
    chk("run.entb", entb, e.enb);      chk("run.u_db", u_db, e.udb);
    chk("run.a", a, p);                chk("run.wrap_cnt", wrap_cnt, wexp);
    chk("run.sync_err", sync_err, sexp);
    if (e.pulse && wexp < 255) wexp++;
  endtask

  // Issue start and check the LOAD cycle.
  task automatic begin_run(input int m, input bit up, input int p);
    mode = 2'(m); dir = up; preset = 4'(p); start = 1'b1;
    step();
    start = 1'b0;
    wexp = 0; sexp = 1'b0;
    chk("load.loadb", loadb, 0);  chk("load.a", a, p);
    chk("load.u_db", u_db, up);   chk("load.busy", busy, 1);
    chk("load.enpb", enpb, 1);    chk("load.entb", entb, 1);
    chk("load.wrap_pulse", wrap_pulse, 0);
    chk("load.wrap_cnt", wrap_cnt, 0);
    chk("load.sync_err", sync_err, 0);
  endtask

  // n RUN cycles; with junk set, scramble dir/mode/preset and poke start while busy.
  task automatic run_cycles(input int m, input bit up, input int p, input int n,
                            input bit junk, output bit still_busy);
    exp_t e;
    still_busy = 1'b1;
    for (int t = 0; t < n; t++) begin
      if (junk) begin
        mode   = 2'($urandom_range(0, 3));
        dir    = 1'($urandom_range(0, 1));
        preset = 4'($urandom_range(0, 15));
        start  = still_busy && ($urandom_range(0, 5) == 0);
      end
      step();
      start = 1'b0;
      check_run(m, up, p, t, e);
      still_busy = e.busy;
    end
  endtask

  // Stop (optionally with start in the same cycle); counter freezes after its last move.
  task automatic end_stop(input int m, input bit up, input int p, input int n, input bit with_start);
    exp_t e = ref_at(m, up, p, n);
    stop = 1'b1; start = with_start;
    step();
    stop = 1'b0; start = 1'b0;
    chk("stop.busy", busy, 0);        chk("stop.loadb", loadb, 1);
    chk("stop.enpb", enpb, 1);        chk("stop.entb", entb, 1);
    chk("stop.wrap_pulse", wrap_pulse, 0);
    chk("stop.wrap_cnt", wrap_cnt, wexp);
    chk("stop.sync_err", sync_err, sexp);
    chk("stop.q", q, e.q);
    step();
    chk("stop.frozen_q", q, e.q);
    chk("stop.idle_busy", busy, 0);
  endtask

  task automatic end_rst(input int m, input bit up, input int p, input int n);
    exp_t e = ref_at(m, up, p, n);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wexp = 0; sexp = 1'b0;
    check_reset("midrst");
    step();
    chk("midrst.frozen_q", q, e.q);
  endtask

  initial begin
    bit   b;
    exp_t e;
    int   m, p, n, act;
    bit   up;

    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b1; mode = 2'd0; preset = 4'd0;
    step(); step();
    check_reset("reset");
    rst = 1'b0;
    step();
    check_reset("idle");

    // Auto-reload from 12: 12,13,14,15,12,...
    begin_run(1, 1'b1, 12); run_cycles(1, 1'b1, 12, 20, 1'b0, b); end_stop(1, 1'b1, 12, 20, 1'b0);
    // One-shot down from 3: 3,2,1,0 then hold; start from DONE afterwards.
    begin_run(2, 1'b0, 3);  run_cycles(2, 1'b0, 3, 8, 1'b0, b);
    chk("oneshot.wrap_cnt", wrap_cnt, 1);
    // Ping-pong from 0 over 40 cycles.
    begin_run(3, 1'b1, 0);  run_cycles(3, 1'b1, 0, 40, 1'b0, b); end_stop(3, 1'b1, 0, 40, 1'b0);
    // Reload with preset at terminal: held at 15, pulse every cycle.
    begin_run(1, 1'b1, 15); run_cycles(1, 1'b1, 15, 8, 1'b0, b); end_stop(1, 1'b1, 15, 8, 1'b0);
    // Free-run for 300 wraps: wrap_cnt saturates.
    begin_run(0, 1'b1, 0);  run_cycles(0, 1'b1, 0, 300 * 16 + 3, 1'b0, b);
    chk("sat.wrap_cnt", wrap_cnt, 255);
    end_stop(0, 1'b1, 0, 300 * 16 + 3, 1'b1);

    // RCOB forced high at q=15 in free-run: sync_err sets and sticks.
    begin_run(0, 1'b1, 0);
    for (int t = 0; t < 40; t++) begin
      step();
      flip = 1'b0;
      check_run(0, 1'b1, 0, t, e);
      if (t == 15) begin flip = 1'b1; sexp = 1'b1; end
    end
    end_stop(0, 1'b1, 0, 40, 1'b0);
    chk("fault.sticky", sync_err, 1);

    // Reset in the middle of a run.
    begin_run(0, 1'b0, 9); run_cycles(0, 1'b0, 9, 7, 1'b0, b); end_rst(0, 1'b0, 9, 7);

    // Randomized runs with ignored input churn and random endings.
    for (int s = 0; s < 40; s++) begin
      m  = $urandom_range(0, 3);
      up = 1'($urandom_range(0, 1));
      p  = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) p = up ? 15 : 0;
      n  = $urandom_range(1, 45);
      begin_run(m, up, p);
      run_cycles(m, up, p, n, 1'b1, b);
      act = $urandom_range(0, 2);
      if (act == 1) end_rst(m, up, p, n);
      else if (act == 0 || b) end_stop(m, up, p, n, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
